// File: rtl/add_64bit_serial.sv
// add_64bit_serial: digit-serial 64-bit adder, DIGIT bits per cycle, with carry-out and signed overflow.
// Define ADD_SERIAL_CC_EN to add registered zero (zf) and sign (sf) flags.
module add_64bit_serial #(
   parameter int DIGIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] sum,
   output logic        cout,
   output logic        overflow
`ifdef ADD_SERIAL_CC_EN
   ,
   output logic        zf,
   output logic        sf
`endif
);
   localparam int NDIG = 64 / DIGIT;
   localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
   if (DIGIT != 1 && DIGIT != 2 && DIGIT != 4 && DIGIT != 8 && DIGIT != 16 && DIGIT != 32 && DIGIT != 64) begin : g_bad_digit
      $error("add_64bit_serial: DIGIT must be a power of two from 1 to 64");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t          st;
   logic [CW-1:0]   cnt;
   logic [63:0]     la, lb;
   logic            carry;
   logic [DIGIT-1:0] da, db, dsum;
   logic            dc;
   logic            last;
   always_comb begin
      da = la[cnt*DIGIT +: DIGIT];
      db = lb[cnt*DIGIT +: DIGIT];
      {dc, dsum} = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry};
      last = cnt == CW'(NDIG - 1);
   end
`ifdef ADD_SERIAL_CC_EN
   // nz accumulates "some digit so far was nonzero" so zf never needs a wide compare
   logic nz;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         cnt      <= '0;
         carry    <= 1'b0;
         la       <= '0;
         lb       <= '0;
`ifdef ADD_SERIAL_CC_EN
         nz       <= 1'b0;
         zf       <= 1'b0;
         sf       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (st == RUN) begin
            sum[cnt*DIGIT +: DIGIT] <= dsum;
            carry <= dc;
            cnt   <= cnt + CW'(1);
`ifdef ADD_SERIAL_CC_EN
            nz    <= nz | (|dsum);
`endif
            if (last) begin
               st       <= DONE;
               busy     <= 1'b0;
               done     <= 1'b1;
               cout     <= dc;
               overflow <= (la[63] == lb[63]) && (dsum[DIGIT-1] != la[63]);
`ifdef ADD_SERIAL_CC_EN
               zf       <= ~(nz | (|dsum));
               sf       <= dsum[DIGIT-1];
`endif
            end
         end else if (start) begin
            st    <= RUN;
            busy  <= 1'b1;
            la    <= a;
            lb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
`ifdef ADD_SERIAL_CC_EN
            nz    <= 1'b0;
`endif
         end else begin
            st <= IDLE;
         end
      end
   end
endmodule
